// File: rtl/alu_seq_unit.sv
// alu_seq_unit: ALU-control decoder plus execute unit.
// Add/sub/and/or/address-add finish in one cycle; signed multiply
// (shift/add) and signed divide (restoring) take WIDTH+2 cycles.
// Results are handed back through a start/busy/done handshake.
module alu_seq_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_alu_op,
    input  logic [3:0]       i_funct,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_result_hi,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_ovf,
    output logic             o_dz,
    output logic             o_illegal
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] C_ADD = 3'b000;
    localparam logic [2:0] C_SUB = 3'b001;
    localparam logic [2:0] C_MUL = 3'b010;
    localparam logic [2:0] C_DIV = 3'b011;
    localparam logic [2:0] C_AND = 3'b100;
    localparam logic [2:0] C_OR  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_SIGN = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [2:0]         r_ctrl;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_result_hi;
    logic               r_ovf;
    logic               r_dz;
    logic               r_illegal;

    logic [2:0]         w_ctrl;
    logic               w_illegal;
    logic               w_accept;
    logic               w_is_multi;
    logic               w_is_dz;
    logic [WIDTH-1:0]   w_b_eff;
    logic [WIDTH-1:0]   w_sum;
    logic               w_add_ovf;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_upper;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH-1:0]   w_quo_s;
    logic [WIDTH-1:0]   w_rem_s;
    logic               w_div_ovf;

    // Decode ALUop/funct into the 3-bit operation code.
    always_comb begin
        w_ctrl    = C_ADD;
        w_illegal = 1'b0;
        case (i_alu_op)
            2'b00: begin
                case (i_funct)
                    4'b0000: w_ctrl = C_ADD;
                    4'b0001: w_ctrl = C_SUB;
                    4'b0100: w_ctrl = C_MUL;
                    4'b0101: w_ctrl = C_DIV;
                    default: w_illegal = 1'b1;
                endcase
            end
            2'b01:   w_ctrl = C_AND;
            2'b10:   w_ctrl = C_OR;
            default: w_ctrl = C_ADD;   // address add for loads/stores
        endcase
    end

    // Single-cycle arithmetic, operand magnitudes and accept qualification.
    always_comb begin
        w_accept   = (r_state == S_IDLE) && i_start;
        w_b_eff    = (w_ctrl == C_SUB) ? (~i_b + 1'b1) : i_b;
        w_sum      = i_a + w_b_eff;
        w_add_ovf  = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != i_a[WIDTH-1]);
        // Most-negative maps onto itself, which is the correct unsigned magnitude.
        w_mag_a    = i_a[WIDTH-1] ? (~i_a + 1'b1) : i_a;
        w_mag_b    = i_b[WIDTH-1] ? (~i_b + 1'b1) : i_b;
        w_is_dz    = !w_illegal && (w_ctrl == C_DIV) && (i_b == '0);
        w_is_multi = !w_illegal && ((w_ctrl == C_MUL) ||
                                    ((w_ctrl == C_DIV) && (i_b != '0)));
    end

    // One iteration of shift/add multiply or restoring divide.
    always_comb begin
        w_mul_upper = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_mag_a} : {(WIDTH+1){1'b0}});
        // Remainder after the left shift; its top bit is always 0 because
        // the remainder stays below |b| <= 2^(WIDTH-1).
        w_rem_sh    = r_acc[2*WIDTH-1:WIDTH-1];
        w_trial     = w_rem_sh - {1'b0, r_mag_b};
        w_acc_next  = r_acc;
        if (r_ctrl == C_MUL) begin
            w_acc_next = {w_mul_upper, r_acc[WIDTH-1:1]};
        end else if (!w_trial[WIDTH]) begin
            w_acc_next = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end else begin
            w_acc_next = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fix-up of the unsigned product / quotient / remainder.
    always_comb begin
        w_prod_s  = r_neg_q ? (~r_acc + 1'b1) : r_acc;
        w_quo_s   = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
        w_rem_s   = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
        // Only most-negative / -1 yields a positive quotient of 2^(WIDTH-1).
        w_div_ovf = !r_neg_q && r_acc[WIDTH-1];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = w_is_multi ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_state_next = S_SIGN;
                end
            end
            S_SIGN:  w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in RUN, publish results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl      <= C_ADD;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mag_a     <= '0;
            r_mag_b     <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_ovf       <= 1'b0;
            r_dz        <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ctrl <= w_ctrl;
                        if (w_is_multi) begin
                            r_mag_a <= w_mag_a;
                            r_mag_b <= w_mag_b;
                            r_neg_q <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
                            r_neg_r <= i_a[WIDTH-1];
                            r_cnt   <= CW'(WIDTH);
                            r_acc   <= (w_ctrl == C_MUL) ? {{WIDTH{1'b0}}, w_mag_b}
                                                         : {{WIDTH{1'b0}}, w_mag_a};
                        end else begin
                            r_result_hi <= '0;
                            r_ovf       <= 1'b0;
                            r_dz        <= 1'b0;
                            r_illegal   <= 1'b0;
                            if (w_illegal) begin
                                r_result  <= '0;
                                r_illegal <= 1'b1;
                            end else if (w_is_dz) begin
                                r_result    <= '1;
                                r_result_hi <= i_a;
                                r_dz        <= 1'b1;
                            end else if (w_ctrl == C_AND) begin
                                r_result <= i_a & i_b;
                            end else if (w_ctrl == C_OR) begin
                                r_result <= i_a | i_b;
                            end else begin
                                r_result <= w_sum;
                                r_ovf    <= w_add_ovf;
                            end
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - 1'b1;
                end
                S_SIGN: begin
                    r_dz      <= 1'b0;
                    r_illegal <= 1'b0;
                    if (r_ctrl == C_MUL) begin
                        r_result    <= w_prod_s[WIDTH-1:0];
                        r_result_hi <= w_prod_s[2*WIDTH-1:WIDTH];
                        r_ovf       <= 1'b0;
                    end else begin
                        r_result    <= w_quo_s;
                        r_result_hi <= w_rem_s;
                        r_ovf       <= w_div_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_result    = r_result;
    assign o_result_hi = r_result_hi;
    assign o_ovf       = r_ovf;
    assign o_dz        = r_dz;
    assign o_illegal   = r_illegal;
    assign o_busy      = (r_state == S_RUN) || (r_state == S_SIGN);
    assign o_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_alu_seq_unit.sv
// Scoreboard bench for alu_seq_unit (WIDTH=16): the driver pushes the
// reference-model response on each issued op, the monitor pops and
// compares whenever done pulses.
module tb_alu_seq_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   alu_op = '0;
    logic [3:0]   funct = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] result, result_hi;
    logic         busy, done, ovf, dz, illegal;

    alu_seq_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (start),
        .i_alu_op    (alu_op),
        .i_funct     (funct),
        .i_a         (a),
        .i_b         (b),
        .o_result    (result),
        .o_result_hi (result_hi),
        .o_busy      (busy),
        .o_done      (done),
        .o_ovf       (ovf),
        .o_dz        (dz),
        .o_illegal   (illegal)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] res;
        logic [15:0] hi;
        logic        ovf;
        logic        dz;
        logic        ill;
        int          lat;
        int          busy_cycles;
        int unsigned done_cyc;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference model in plain signed integer arithmetic.
    function automatic exp_t model(input logic [1:0] op, input logic [3:0] fn,
                                   input logic [15:0] x, input logic [15:0] y);
        exp_t    e;
        int      sx, sy, sbp, tot, q, r;
        longint  p;
        logic [15:0] bp;
        e.res = '0; e.hi = '0; e.ovf = 1'b0; e.dz = 1'b0; e.ill = 1'b0;
        e.lat = 1; e.busy_cycles = 0; e.done_cyc = 0; e.tag = "";
        sx = $signed(x);
        sy = $signed(y);
        if (op == 2'b01) begin
            e.res = x & y;
        end else if (op == 2'b10) begin
            e.res = x | y;
        end else if (op == 2'b11 || (fn == 4'b0000) || (fn == 4'b0001)) begin
            bp = y;
            if (op == 2'b00 && fn == 4'b0001) bp = 16'h0000 - y;
            sbp   = $signed(bp);
            tot   = sx + sbp;
            e.res = 16'(tot);
            e.ovf = (tot > 32767) || (tot < -32768);
        end else if (fn == 4'b0100) begin
            p     = longint'(sx) * longint'(sy);
            e.res = p[15:0];
            e.hi  = p[31:16];
            e.lat = W + 2;
            e.busy_cycles = W + 1;
        end else if (fn == 4'b0101) begin
            if (y == 16'h0000) begin
                e.res = 16'hFFFF;
                e.hi  = x;
                e.dz  = 1'b1;
            end else begin
                e.lat = W + 2;
                e.busy_cycles = W + 1;
                if (sx == -32768 && sy == -1) begin
                    e.res = 16'h8000;
                    e.ovf = 1'b1;
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    e.res = 16'(q);
                    e.hi  = 16'(r);
                end
            end
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    // Issue one op, optionally poke start while busy, wait for done.
    task automatic run_op(input logic [1:0] op, input logic [3:0] fn,
                          input logic [15:0] x, input logic [15:0] y,
                          input bit poke, input string tag);
        exp_t e;
        @(negedge clk);
        alu_op = op; funct = fn; a = x; b = y; start = 1'b1;
        e = model(op, fn, x, y);
        e.done_cyc = cyc + e.lat;
        e.tag = tag;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        alu_op = 2'($urandom); funct = 4'($urandom);
        for (int k = 0; k < 40 && done !== 1'b1; k++) begin
            start = poke && (k == 3);
            if (start) begin
                alu_op = 2'b00; funct = 4'b0000;
                a = 16'($urandom); b = 16'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        if (done !== 1'b1) exp_q.delete();
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    int   busy_run = 0;
    exp_t me;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                check("busy_done_exclusive", {31'd0, busy}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending op", cyc);
                end else begin
                    me = exp_q.pop_front();
                    check({me.tag, "_result"},    {16'd0, result},    {16'd0, me.res});
                    check({me.tag, "_result_hi"}, {16'd0, result_hi}, {16'd0, me.hi});
                    check({me.tag, "_ovf"},       {31'd0, ovf},       {31'd0, me.ovf});
                    check({me.tag, "_dz"},        {31'd0, dz},        {31'd0, me.dz});
                    check({me.tag, "_illegal"},   {31'd0, illegal},   {31'd0, me.ill});
                    check({me.tag, "_done_cycle"}, cyc,               me.done_cyc);
                    check({me.tag, "_busy_cycles"}, busy_run,         me.busy_cycles);
                    $display("[TB] %s op=%0d fn=%0d -> res=%h hi=%h ovf=%0d dz=%0d ill=%0d cyc=%0d",
                             me.tag, alu_op, funct, result, result_hi, ovf, dz, illegal, cyc);
                end
                busy_run = 0;
            end
        end
    end

    // Stimulus.
    logic [3:0] fns [4] = '{4'b0000, 4'b0001, 4'b0100, 4'b0101};
    initial begin
        logic [1:0]  rop;
        logic [3:0]  rfn;
        logic [15:0] rx, ry;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_result",    {16'd0, result},    32'd0);
        check("rst_result_hi", {16'd0, result_hi}, 32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_done",      {31'd0, done},      32'd0);
        check("rst_flags",     {29'd0, ovf, dz, illegal}, 32'd0);
        rst_n = 1'b1;

        run_op(2'b00, 4'b0000, 16'h7FFF, 16'h0001, 1'b0, "add_ovf");
        run_op(2'b01, 4'b0000, 16'hF0F0, 16'h0FF0, 1'b0, "andi");
        run_op(2'b10, 4'b0000, 16'hF0F0, 16'h0FF0, 1'b0, "ori");
        run_op(2'b11, 4'b0000, 16'h8000, 16'hFFFF, 1'b0, "addr_add_ovf");
        run_op(2'b00, 4'b0001, 16'h8000, 16'h0001, 1'b0, "sub_ovf");
        run_op(2'b00, 4'b0100, 16'hFFFD, 16'h0007, 1'b1, "mult_poke");
        run_op(2'b00, 4'b0101, 16'hFFF9, 16'h0002, 1'b0, "div_neg");
        run_op(2'b00, 4'b0101, 16'h8000, 16'hFFFF, 1'b0, "div_ovf");
        run_op(2'b00, 4'b0101, 16'h1234, 16'h0000, 1'b0, "div_zero");
        run_op(2'b00, 4'b0111, 16'h1234, 16'h5678, 1'b0, "illegal");
        run_op(2'b00, 4'b0100, 16'h8000, 16'h8000, 1'b0, "mult_minneg");
        run_op(2'b00, 4'b0101, 16'h7FFF, 16'hFFFD, 1'b0, "div_posneg");

        // Reset in the middle of a multiply: outputs clear at once, no done.
        @(negedge clk);
        alu_op = 2'b00; funct = 4'b0100; a = 16'h0123; b = 16'h0456; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_result",    {16'd0, result},    32'd0);
        check("abort_result_hi", {16'd0, result_hi}, 32'd0);
        check("abort_busy",      {31'd0, busy},      32'd0);
        check("abort_flags",     {29'd0, ovf, dz, illegal}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        rst_n = 1'b1;
        run_op(2'b00, 4'b0100, 16'h0123, 16'h0456, 1'b0, "mult_after_rst");

        for (int i = 0; i < 80; i++) begin
            rop = 2'($urandom_range(0, 3));
            rfn = ($urandom_range(0, 7) == 0) ? 4'($urandom) : fns[$urandom_range(0, 3)];
            rx  = 16'($urandom);
            ry  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            run_op(rop, rfn, rx, ry, bit'($urandom_range(0, 1)), "rand");
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
